// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the five-port mesh router.
// Port index order on every per-port vector/array: N=0, S=1, E=2, W=3, L=4.
// PORT_NONE (3'd7) marks an idle crossbar select.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t PORT_N    = 3'd0;
    localparam port_idx_t PORT_S    = 3'd1;
    localparam port_idx_t PORT_E    = 3'd2;
    localparam port_idx_t PORT_W    = 3'd3;
    localparam port_idx_t PORT_L    = 3'd4;
    localparam port_idx_t PORT_NONE = 3'd7;

    // Next port index in round-robin order, wrapping L -> N.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == PORT_L) ? PORT_N : port_idx_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// rr_arbiter5: five-way round-robin arbiter for one output port.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - request vector, one bit per input (N,S,E,W,L)
//   en         - output is eligible (downstream credit available)
//   gnt_valid  - a grant is issued this cycle (combinational)
//   gnt_idx    - granted input index, PORT_NONE when idle (combinational)
// The pointer names the highest-priority input and moves just past the
// winner after every grant; it holds otherwise.
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    output logic                 gnt_valid,
    output port_idx_t            gnt_idx
);

    port_idx_t ptr;
    port_idx_t scan_idx;

    // Scan from ptr upward (mod 5); first requesting input wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = PORT_NONE;
        scan_idx  = ptr;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (en && !gnt_valid && req[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
            scan_idx = next_port(scan_idx);
        end
    end

    // Priority pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PORT_N;
        end else if (gnt_valid) begin
            ptr <= next_port(gnt_idx);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-cycle switch allocator and downstream credit tracker
// for the five-port mesh router.
// Ports (index order N=0, S=1, E=2, W=3, L=4):
//   clk, rst      - clock, synchronous active-high reset
//   req_valid_i   - input i has a head-of-queue flit
//   req_port_i    - requested output of input i (5..7 match nothing)
//   credit_inc_i  - output o got one credit back from downstream
//   sel_o         - crossbar select per output, 3'd7 when idle (comb)
//   send_en_o     - output o transmits this cycle (comb)
//   pop_o         - dequeue input i this cycle (comb)
//   full_o        - credit counter of output o is zero
//   err_o         - sticky credit-overflow flag
//   grant_cnt_o   - per-output 16-bit wrapping grant counters
// Optional feature macro: NOC_ALLOC_STATS_EN enables grant_cnt_o.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int unsigned CREDITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  port_idx_t [NUM_PORTS-1:0]     req_port_i,
    input  logic [NUM_PORTS-1:0]          credit_inc_i,
    output port_idx_t [NUM_PORTS-1:0]     sel_o,
    output logic [NUM_PORTS-1:0]          send_en_o,
    output logic [NUM_PORTS-1:0]          pop_o,
    output logic [NUM_PORTS-1:0]          full_o,
    output logic                          err_o
`ifdef NOC_ALLOC_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][15:0]    grant_cnt_o
`endif
);

    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_mat;   // [output][input]
    logic [NUM_PORTS-1:0]                eligible;
    logic [NUM_PORTS-1:0]                gnt_valid;
    port_idx_t [NUM_PORTS-1:0]           gnt_idx;
    logic [NUM_PORTS-1:0]                ovf;
    logic [NUM_PORTS-1:0][CRED_W-1:0]    cnt;

    // Request matrix; out-of-range port codes never match an output.
    always_comb begin
        req_mat = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                req_mat[o][i] = req_valid_i[i] && (req_port_i[i] == port_idx_t'(o));
            end
        end
    end

    // An output may only grant while it holds at least one credit.
    always_comb begin
        eligible = '0;
        full_o   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            eligible[o] = (cnt[o] != '0);
            full_o[o]   = (cnt[o] == '0);
        end
    end

    // One independent arbiter per output.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        rr_arbiter5 u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (req_mat[g]),
            .en        (eligible[g]),
            .gnt_valid (gnt_valid[g]),
            .gnt_idx   (gnt_idx[g])
        );
    end

    // Crossbar selects, enables and pops. Each input requests one output,
    // so at most one output can pop a given input.
    always_comb begin
        sel_o     = gnt_idx;
        send_en_o = gnt_valid;
        pop_o     = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (gnt_valid[o]) begin
                pop_o[gnt_idx[o]] = 1'b1;
            end
        end
    end

    // Credit returned on a full counter with no offsetting grant.
    always_comb begin
        ovf = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            ovf[o] = credit_inc_i[o] && !gnt_valid[o] && (cnt[o] == CRED_W'(CREDITS));
        end
    end

    // Credit counters: grant consumes, inc returns, both cancel; saturate at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                cnt[o] <= CRED_W'(CREDITS);
            end
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (gnt_valid[o] && !credit_inc_i[o]) begin
                    cnt[o] <= cnt[o] - CRED_W'(1);
                end else if (credit_inc_i[o] && !gnt_valid[o] && !ovf[o]) begin
                    cnt[o] <= cnt[o] + CRED_W'(1);
                end
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (|ovf) begin
            err_o <= 1'b1;
        end
    end

`ifdef NOC_ALLOC_STATS_EN
    // Per-output grant statistics, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_o <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (gnt_valid[o]) begin
                    grant_cnt_o[o] <= grant_cnt_o[o] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed self-checking bench for switch_allocator.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Build with +define+NOC_ALLOC_STATS_EN to cover stats.
module tb_switch_allocator;

    logic                 clk;
    logic                 rst;
    logic [4:0]           req_valid;
    logic [4:0][2:0]      req_port;
    logic [4:0]           credit_inc;
    logic [4:0][2:0]      sel;
    logic [4:0]           send_en;
    logic [4:0]           pop;
    logic [4:0]           full;
    logic                 err;
`ifdef NOC_ALLOC_STATS_EN
    logic [4:0][15:0]     grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    switch_allocator #(.CREDITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_port_i   (req_port),
        .credit_inc_i (credit_inc),
        .sel_o        (sel),
        .send_en_o    (send_en),
        .pop_o        (pop),
        .full_o       (full),
        .err_o        (err)
`ifdef NOC_ALLOC_STATS_EN
        ,
        .grant_cnt_o  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_port   = '0;
        credit_inc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0][2:0] all_idle;
        all_idle = {5{3'd7}};
        do_reset();
        @(negedge clk);
        checks++; if (sel !== all_idle) begin errors++; $display("FAIL reset_sel got %h exp %h", sel, all_idle); end
        checks++; if (send_en !== 5'b0) begin errors++; $display("FAIL reset_send_en got %b exp 00000", send_en); end
        checks++; if (pop !== 5'b0) begin errors++; $display("FAIL reset_pop got %b exp 00000", pop); end
        checks++; if (full !== 5'b0) begin errors++; $display("FAIL reset_full got %b exp 00000", full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    // N requests E with no returned credits: four grants, then stalls.
    task automatic test_credit_exhaustion();
        do_reset();
        req_valid[0] = 1'b1;
        req_port[0]  = 3'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (pop[0] !== (c < 4)) begin errors++; $display("FAIL exhaust_pop c=%0d got %b exp %b", c, pop[0], (c < 4)); end
            checks++; if (sel[2] !== ((c < 4) ? 3'd0 : 3'd7)) begin errors++; $display("FAIL exhaust_sel c=%0d got %0d", c, sel[2]); end
            checks++; if (full[2] !== (c >= 4)) begin errors++; $display("FAIL exhaust_full c=%0d got %b exp %b", c, full[2], (c >= 4)); end
            step();
        end
        credit_inc[2] = 1'b1;
        @(negedge clk);
        checks++; if (pop[0] !== 1'b0) begin errors++; $display("FAIL credit_same_cycle_pop got %b exp 0", pop[0]); end
        step();
        credit_inc[2] = 1'b0;
        @(negedge clk);
        checks++; if (pop[0] !== 1'b1) begin errors++; $display("FAIL credit_next_cycle_pop got %b exp 1", pop[0]); end
        checks++; if (send_en !== 5'b00100) begin errors++; $display("FAIL credit_next_cycle_en got %b exp 00100", send_en); end
        step();
        @(negedge clk);
        checks++; if (pop[0] !== 1'b0) begin errors++; $display("FAIL credit_after_pop got %b exp 0", pop[0]); end
        checks++; if (full[2] !== 1'b1) begin errors++; $display("FAIL credit_after_full got %b exp 1", full[2]); end
        step();
        idle_inputs();
    endtask

    // N, E, W, L contend for L; credit returned every cycle.
    task automatic test_round_robin();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd0, 3'd2};
        do_reset();
        req_valid  = 5'b11101;
        req_port   = {5{3'd4}};
        credit_inc = 5'b10000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (sel[4] !== exp_seq[c]) begin errors++; $display("FAIL rr_sel c=%0d got %0d exp %0d", c, sel[4], exp_seq[c]); end
            checks++; if (pop !== (5'b1 << exp_seq[c])) begin errors++; $display("FAIL rr_pop c=%0d got %b", c, pop); end
            step();
        end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", err); end
        idle_inputs();
        step();
    endtask

    // Grant and credit in the same cycle on W at cnt=1 leave cnt at 1.
    task automatic test_simul_grant_credit();
        do_reset();
        req_valid[0] = 1'b1;
        req_port[0]  = 3'd3;
        repeat (3) step();
        credit_inc[3] = 1'b1;
        @(negedge clk);
        checks++; if (send_en[3] !== 1'b1) begin errors++; $display("FAIL simul_en got %b exp 1", send_en[3]); end
        checks++; if (full[3] !== 1'b0) begin errors++; $display("FAIL simul_full got %b exp 0", full[3]); end
        step();
        credit_inc[3] = 1'b0;
        @(negedge clk);
        checks++; if (full[3] !== 1'b0) begin errors++; $display("FAIL simul_hold_full got %b exp 0", full[3]); end
        checks++; if (send_en[3] !== 1'b1) begin errors++; $display("FAIL simul_hold_en got %b exp 1", send_en[3]); end
        step();
        @(negedge clk);
        checks++; if (full[3] !== 1'b1) begin errors++; $display("FAIL simul_drain_full got %b exp 1", full[3]); end
        checks++; if (send_en[3] !== 1'b0) begin errors++; $display("FAIL simul_drain_en got %b exp 0", send_en[3]); end
        idle_inputs();
        step();
    endtask

    task automatic test_overflow_invalid();
        logic [4:0][2:0] all_idle;
        all_idle = {5{3'd7}};
        do_reset();
        credit_inc[1] = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", err); end
        step();
        credit_inc[1] = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", err); end
        checks++; if (full[1] !== 1'b0) begin errors++; $display("FAIL ovf_full got %b exp 0", full[1]); end
        repeat (3) step();
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", err); end
        req_valid[4] = 1'b1;
        req_port[4]  = 3'd5;
        step();
        @(negedge clk);
        checks++; if (pop !== 5'b0) begin errors++; $display("FAIL invalid5_pop got %b exp 00000", pop); end
        checks++; if (send_en !== 5'b0) begin errors++; $display("FAIL invalid5_en got %b exp 00000", send_en); end
        req_port[4] = 3'd7;
        step();
        @(negedge clk);
        checks++; if (pop !== 5'b0) begin errors++; $display("FAIL invalid7_pop got %b exp 00000", pop); end
        checks++; if (sel !== all_idle) begin errors++; $display("FAIL invalid7_sel got %h exp %h", sel, all_idle); end
        do_reset();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", err); end
    endtask

    // Reset during traffic: grant still shown, state restarts.
    task automatic test_reset_mid_traffic();
        do_reset();
        req_valid[0] = 1'b1;
        req_port[0]  = 3'd2;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (pop[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pop got %b exp 1", pop[0]); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (pop[0] !== (c < 4)) begin errors++; $display("FAIL rst_mid_refill c=%0d got %b exp %b", c, pop[0], (c < 4)); end
            step();
        end
        idle_inputs();
    endtask

`ifdef NOC_ALLOC_STATS_EN
    task automatic test_stats();
        do_reset();
        req_valid[0]  = 1'b1;
        req_port[0]   = 3'd0;
        credit_inc[0] = 1'b1;
        repeat (10) step();
        idle_inputs();
        @(negedge clk);
        checks++; if (grant_cnt[0] !== 16'd10) begin errors++; $display("FAIL stats_n got %0d exp 10", grant_cnt[0]); end
        checks++; if (grant_cnt[4:1] !== '0) begin errors++; $display("FAIL stats_others got %h exp 0", grant_cnt[4:1]); end
        do_reset();
        @(negedge clk);
        checks++; if (grant_cnt[0] !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d exp 0", grant_cnt[0]); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_credit_exhaustion();
        test_round_robin();
        test_simul_grant_credit();
        test_overflow_invalid();
        test_reset_mid_traffic();
`ifdef NOC_ALLOC_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

- Per-cycle switch allocator and credit tracker for the five-port mesh router.
- Sits between the routing logic and the input ports, output ports and crossbar.
- Each output port grants one head-of-queue input using an independent round-robin pointer, and only when downstream credit is available.
- Drives the crossbar selects, the output enables and the input pops, and counts downstream credits per output.

## Interface

Parameters:
- CREDITS, default 4: downstream buffer depth per output; the credit counter reset value and maximum.
- CRED_W, default $clog2(CREDITS+1): credit counter width. Derived localparam; not overridden.

Ports (index order N=0, S=1, E=2, W=3, L=4 on every 5-bit vector and every 5x3 array):
- clk  in  1  router clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  5  input i has a flit at the head of its queue.
- req_port_i  in  5x3  requested output port of input i, from routing logic.
- credit_inc_i  in  5  output o received one returned credit from downstream.
- sel_o  out  5x3  crossbar select per output: granted input index, or 3'd7 when idle.
- send_en_o  out  5  output o transmits this cycle.
- pop_o  out  5  dequeue input i this cycle.
- full_o  out  5  credit counter of output o is zero.
- err_o  out  1  sticky credit-overflow flag.
- grant_cnt_o  out  5x16  per-output grant counters. Present only with NOC_ALLOC_STATS_EN.

## Operation

Request matrix:
- req[o][i] = req_valid_i[i] && req_port_i[i]==o.
- req_port_i values 5–7 never match any output. Such an input is never popped.

Allocation, per output o, combinational:
- eligible = (cnt[o] != 0).
- Scan inputs ptr[o], ptr[o]+1, … mod 5. The first i with req[o][i] wins.
- Each input requests exactly one output, so each input holds at most one grant.

Outputs on a grant (o, i):
- sel_o[o]=i, send_en_o[o]=1, pop_o[i]=1.

Outputs with no grant:
- sel_o[o]=7, send_en_o[o]=0.

Round-robin pointer:
- On a grant to input i, ptr[o] <= (i+1) mod 5.
- Otherwise ptr[o] holds.

Credit counter cnt[o]:
- Grant and no inc: decrement.
- inc and no grant: increment.
- Grant and inc in the same cycle: unchanged.

Credit overflow:
- inc with no grant while cnt[o]==CREDITS: counter holds at CREDITS and err_o <= 1.
- err_o stays set until rst.

Other definitions:
- full_o[o] = (cnt[o]==0).
- cnt[o] never underflows; an ineligible output issues no grant.

## Timing

- Zero-cycle allocation: grants, pops, selects and enables are combinational from the current inputs and registered state in the same cycle.
- ptr, cnt and err_o update on the rising clk edge.
- A credit returned in cycle t makes the output eligible in cycle t+1.
- Reset values (state assigned on rst while the edge is sampled, overriding any concurrent grant or credit):
  - ptr=0, cnt=CREDITS, err_o=0, grant_cnt_o=0.
  - Therefore sel_o=7, send_en_o=0, pop_o=0 and full_o=0 whenever the inputs are idle.
- Reset mid-traffic: grants in the reset cycle are still presented combinationally, but the state ignores them.
  - Credits and pointers restart from their reset values.
- Simultaneous events on different outputs are independent.

## Configuration

NOC_ALLOC_STATS_EN:
- Defined: grant_cnt_o exists. Each 16-bit counter increments on every grant of its output and wraps from 0xFFFF to 0. Reset to 0.
- Undefined: the port and counters are absent. Allocation behaviour is identical.

## Structure

Shared package noc_pkg holds:
- port index constants PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4, PORT_NONE=3'd7;
- NUM_PORTS=5;
- the port_idx_t 3-bit typedef.

Sub-module rr_arbiter5:
- One per output; instantiated five times.
- Contains the 5-bit request vector, the pointer register, the grant index and the grant-valid logic.
- Credit counters and the error flag stay in switch_allocator.

## Test plan

- Reset: assert rst for 2 cycles with all inputs idle -> sel_o all 7, send_en_o=0, pop_o=0, full_o=0, err_o=0.
- Credit exhaustion: N requests E continuously with no credit_inc -> pop_o[0]=1 for exactly 4 cycles, then full_o[2]=1 and no grant. A single credit_inc_i[2] pulse -> exactly one grant on the next cycle.
- Round robin: N, E, W, L all request L with credit_inc_i[4] every cycle -> sel_o[4] sequence 0,2,3,4,0,2…
- Simultaneous grant and credit at cnt=1 on output W -> cnt stays 1 and full_o[3] stays 0. The next cycle without inc -> full_o[3]=1.
- Overflow and invalid request: credit_inc_i[1] with cnt[1]=4 -> err_o=1 and stays 1 until rst. req_port_i[4]=5 with req_valid_i[4]=1 -> pop_o[4]=0 and all send_en_o=0.
- Stats (NOC_ALLOC_STATS_EN defined): 10 grants on output N -> grant_cnt_o[0]=10. rst -> 0.
